// File: rtl/cr_xp10_decomp_fe_lfa_rd_ctrl.sv
// LFA FIFO read arbiter: round-robin cursors, commit/rewind, head release; optional stall stats via LFA_RD_CTRL_STATS_EN.
// Grant and read same cycle, rvalid/rdata one cycle later; fifo_rd_avail=0 stalls the candidate and rotates priority.
module cr_xp10_decomp_fe_lfa_rd_ctrl #(
    parameter int NREQ = 2,
    parameter int DW   = 70
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] cfg_req_en,
    input  logic [NREQ-1:0] rreq,
    input  logic [NREQ-1:0] commit,
    input  logic [NREQ-1:0] rewind,
    input  logic            flush,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] rvalid,
    output logic [DW-1:0]   rdata,
    output logic            fifo_rd,
    output logic [9:0]      fifo_raddr,
    input  logic            fifo_rd_avail,
    input  logic [DW-1:0]   fifo_rdata,
    input  logic [9:0]      fifo_waddr,
    output logic            fifo_rd_ack,
    output logic [9:0]      fifo_rd_ack_addr,
    output logic [15:0]     stall_cnt
);

    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [9:0]        cur_q [NREQ];
    logic [9:0]        cmt_q [NREQ];
    logic [9:0]        head_q;
    logic [RRW-1:0]    rr_ptr_q;
    logic [NREQ-1:0]   rvalid_q;
    logic [DW-1:0]     rdata_q;
    logic              ack_q;
    logic [9:0]        ack_addr_q;

    logic [NREQ-1:0]   elig;
    logic              cand_vld;
    logic [RRW-1:0]    cand_idx;
    logic [RRW-1:0]    cand_nxt;
    logic              run;
    logic              grant_ok;
    logic              rel_any;
    logic [9:0]        rel_d;
    logic              rel_fire;

    function automatic logic [RRW-1:0] rr_idx(input logic [RRW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return RRW'(s);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Round-robin candidate: a rewinding requester sits out this cycle
    always_comb begin
        elig     = rreq & cfg_req_en & ~rewind;
        cand_vld = 1'b0;
        cand_idx = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!cand_vld && elig[rr_idx(rr_ptr_q, k)]) begin
                cand_vld = 1'b1;
                cand_idx = rr_idx(rr_ptr_q, k);
            end
        end
        cand_nxt = rr_idx(cand_idx, 1);
    end

    // Outputs
    always_comb begin
        run        = (state_q == ST_RUN) && !rst;
        fifo_rd    = run && cand_vld;
        fifo_raddr = cur_q[cand_idx];
        grant_ok   = fifo_rd && fifo_rd_avail;
        gnt        = grant_ok ? (NREQ'(1) << cand_idx) : '0;
        rvalid     = rst ? '0 : rvalid_q;
        rdata      = (|rvalid) ? fifo_rdata : rdata_q;
    end

    // Release distance is the smallest committed lead over head among enabled requesters
    always_comb begin
        rel_any = 1'b0;
        rel_d   = 10'h3FF;
        for (int i = 0; i < NREQ; i++) begin
            if (cfg_req_en[i]) begin
                rel_any = 1'b1;
                if (10'(cmt_q[i] - head_q) < rel_d) rel_d = 10'(cmt_q[i] - head_q);
            end
        end
        rel_fire = rel_any && (rel_d != 10'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cur_q[i] <= 10'd0;
                cmt_q[i] <= 10'd0;
            end
        end else if (state_q == ST_FLUSH) begin
            for (int i = 0; i < NREQ; i++) begin
                cur_q[i] <= fifo_waddr;
                cmt_q[i] <= fifo_waddr;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                // commit together with rewind cancels out
                if (commit[i] && !rewind[i]) cmt_q[i] <= cur_q[i];
                if (rewind[i] && !commit[i]) cur_q[i] <= cmt_q[i];
                else if (gnt[i])             cur_q[i] <= cur_q[i] + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (run && cand_vld) begin
            rr_ptr_q <= cand_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= 10'd0;
            ack_q      <= 1'b0;
            ack_addr_q <= 10'd0;
        end else if (state_q == ST_FLUSH) begin
            head_q     <= fifo_waddr;
            ack_q      <= 1'b1;
            ack_addr_q <= fifo_waddr;
        end else begin
            ack_q <= rel_fire;
            if (rel_fire) begin
                head_q     <= head_q + rel_d;
                ack_addr_q <= head_q + rel_d;
            end
        end
    end

    assign fifo_rd_ack      = ack_q;
    assign fifo_rd_ack_addr = ack_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt;
            if (|rvalid_q) rdata_q <= fifo_rdata;
        end
    end

`ifdef LFA_RD_CTRL_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stall_q <= 16'd0;
        end else if (run && cand_vld && !fifo_rd_avail && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cr_xp10_decomp_fe_lfa_rd_ctrl.sv
// Directed bench for cr_xp10_decomp_fe_lfa_rd_ctrl with a one-cycle-latency FIFO stub.
module tb_cr_xp10_decomp_fe_lfa_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_req_en;
    logic [1:0]  rreq;
    logic [1:0]  commit;
    logic [1:0]  rewind;
    logic        flush;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [69:0] rdata;
    logic        fifo_rd;
    logic [9:0]  fifo_raddr;
    logic        fifo_rd_avail;
    logic [69:0] fifo_rdata = '0;
    logic [9:0]  fifo_waddr;
    logic        fifo_rd_ack;
    logic [9:0]  fifo_rd_ack_addr;
    logic [15:0] stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    cr_xp10_decomp_fe_lfa_rd_ctrl #(.NREQ(2), .DW(70)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_req_en       (cfg_req_en),
        .rreq             (rreq),
        .commit           (commit),
        .rewind           (rewind),
        .flush            (flush),
        .gnt              (gnt),
        .rvalid           (rvalid),
        .rdata            (rdata),
        .fifo_rd          (fifo_rd),
        .fifo_raddr       (fifo_raddr),
        .fifo_rd_avail    (fifo_rd_avail),
        .fifo_rdata       (fifo_rdata),
        .fifo_waddr       (fifo_waddr),
        .fifo_rd_ack      (fifo_rd_ack),
        .fifo_rd_ack_addr (fifo_rd_ack_addr),
        .stall_cnt        (stall_cnt)
    );

    always #5 clk = ~clk;

    // FIFO stub: word at address a reads back as {60'hABC, a}
    always @(posedge clk) begin
        if (fifo_rd) fifo_rdata <= {60'hABC, fifo_raddr};
    end

    function automatic logic [69:0] word(input int a);
        logic [9:0] a10;
        a10 = 10'(a);
        return {60'hABC, a10};
    endfunction

    task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge; checks follow at +2ns
    task automatic step(input logic r, input logic [1:0] en, input logic [1:0] rq, input logic av,
                        input logic [1:0] cm, input logic [1:0] rw, input logic fl);
        @(negedge clk);
        rst           = r;
        cfg_req_en    = en;
        rreq          = rq;
        fifo_rd_avail = av;
        commit        = cm;
        rewind        = rw;
        flush         = fl;
        #2;
    endtask

    initial begin
        rst = 1'b1; cfg_req_en = 2'b11; rreq = '0; commit = '0; rewind = '0;
        flush = 1'b0; fifo_rd_avail = 1'b0; fifo_waddr = 10'd0;

        step(1, 2'b11, 2'b11, 1, 0, 0, 0);
        step(1, 2'b11, 2'b11, 1, 0, 0, 0);
        chk("rst_gnt",      70'(gnt), 70'(0));
        chk("rst_fifo_rd",  70'(fifo_rd), 70'(0));
        chk("rst_rvalid",   70'(rvalid), 70'(0));
        chk("rst_rdata",    rdata, 70'(0));
        chk("rst_ack",      70'(fifo_rd_ack), 70'(0));
        chk("rst_ack_addr", 70'(fifo_rd_ack_addr), 70'(0));
        chk("rst_stall",    70'(stall_cnt), 70'(0));

        // Round-robin with both requesters reading
        step(0, 2'b11, 2'b11, 1, 0, 0, 0);
        chk("rr0_gnt", 70'(gnt), 70'(1)); chk("rr0_raddr", 70'(fifo_raddr), 70'(0));
        chk("rr0_rd", 70'(fifo_rd), 70'(1));
        step(0, 2'b11, 2'b11, 1, 0, 0, 0);
        chk("rr1_gnt", 70'(gnt), 70'(2)); chk("rr1_raddr", 70'(fifo_raddr), 70'(0));
        chk("rr1_rvalid", 70'(rvalid), 70'(1)); chk("rr1_rdata", rdata, word(0));
        step(0, 2'b11, 2'b11, 1, 0, 0, 0);
        chk("rr2_gnt", 70'(gnt), 70'(1)); chk("rr2_raddr", 70'(fifo_raddr), 70'(1));
        chk("rr2_rvalid", 70'(rvalid), 70'(2)); chk("rr2_rdata", rdata, word(0));
        step(0, 2'b11, 2'b11, 1, 0, 0, 0);
        chk("rr3_gnt", 70'(gnt), 70'(2)); chk("rr3_raddr", 70'(fifo_raddr), 70'(1));
        chk("rr3_rvalid", 70'(rvalid), 70'(1)); chk("rr3_rdata", rdata, word(1));
        step(0, 2'b11, 2'b00, 1, 0, 0, 0);
        chk("rr4_gnt", 70'(gnt), 70'(0)); chk("rr4_rvalid", 70'(rvalid), 70'(2));
        chk("rr4_rdata", rdata, word(1));
        step(0, 2'b11, 2'b00, 1, 0, 0, 0);
        chk("rr5_rvalid", 70'(rvalid), 70'(0)); chk("rr5_rdata_hold", rdata, word(1));
        chk("rr5_ack", 70'(fifo_rd_ack), 70'(0));

        // Commit both to 2: release fires two cycles after the last commit
        step(0, 2'b11, 2'b00, 0, 2'b01, 0, 0);
        step(0, 2'b11, 2'b00, 0, 2'b10, 0, 0);
        step(0, 2'b11, 2'b00, 0, 0, 0, 0);
        chk("rel_early_ack", 70'(fifo_rd_ack), 70'(0));
        step(0, 2'b11, 2'b00, 0, 0, 0, 0);
        chk("rel_ack", 70'(fifo_rd_ack), 70'(1)); chk("rel_addr", 70'(fifo_rd_ack_addr), 70'(2));
        step(0, 2'b11, 2'b00, 0, 0, 0, 0);
        chk("rel_once", 70'(fifo_rd_ack), 70'(0)); chk("rel_addr_hold", 70'(fifo_rd_ack_addr), 70'(2));

        // Rewind: cur0 5 -> 2
        step(0, 2'b11, 2'b01, 1, 0, 0, 0); chk("rw_a", 70'(fifo_raddr), 70'(2));
        step(0, 2'b11, 2'b01, 1, 0, 0, 0); chk("rw_b", 70'(fifo_raddr), 70'(3));
        step(0, 2'b11, 2'b01, 1, 0, 0, 0); chk("rw_c", 70'(fifo_raddr), 70'(4));
        step(0, 2'b11, 2'b01, 1, 0, 2'b01, 0);
        chk("rw_gnt", 70'(gnt), 70'(0)); chk("rw_rd", 70'(fifo_rd), 70'(0));
        chk("rw_rvalid", 70'(rvalid), 70'(1));
        step(0, 2'b11, 2'b01, 1, 0, 0, 0);
        chk("rw_raddr", 70'(fifo_raddr), 70'(2)); chk("rw_gnt_after", 70'(gnt), 70'(1));
        chk("rw_rvalid_after", 70'(rvalid), 70'(0));
        // commit+rewind together leaves cur0 at 3
        step(0, 2'b11, 2'b01, 1, 2'b01, 2'b01, 0); chk("cmrw_gnt", 70'(gnt), 70'(0));
        step(0, 2'b11, 2'b01, 1, 0, 0, 0);
        chk("cmrw_raddr", 70'(fifo_raddr), 70'(3)); chk("cmrw_gnt_after", 70'(gnt), 70'(1));

        // Stall rotates priority: cand 1 (cur1=2) then cand 0 (cur0=4)
        step(0, 2'b11, 2'b11, 0, 0, 0, 0);
        chk("stl0_gnt", 70'(gnt), 70'(0)); chk("stl0_rd", 70'(fifo_rd), 70'(1));
        chk("stl0_raddr", 70'(fifo_raddr), 70'(2));
        step(0, 2'b11, 2'b11, 0, 0, 0, 0);
        chk("stl1_gnt", 70'(gnt), 70'(0)); chk("stl1_raddr", 70'(fifo_raddr), 70'(4));

        // Flush to 300
        fifo_waddr = 10'd300;
        step(0, 2'b11, 2'b00, 0, 0, 0, 1);
        step(0, 2'b11, 2'b01, 1, 0, 0, 0);
        chk("fl_gnt", 70'(gnt), 70'(0)); chk("fl_rd", 70'(fifo_rd), 70'(0));
        chk("fl_stall_clr", 70'(stall_cnt), 70'(0));
        step(0, 2'b11, 2'b01, 1, 0, 0, 0);
        chk("fl_ack", 70'(fifo_rd_ack), 70'(1)); chk("fl_ack_addr", 70'(fifo_rd_ack_addr), 70'(300));
        chk("fl_raddr", 70'(fifo_raddr), 70'(300)); chk("fl_gnt_after", 70'(gnt), 70'(1));
        step(0, 2'b11, 2'b00, 0, 0, 0, 0);
        chk("fl_ack_once", 70'(fifo_rd_ack), 70'(0));

        // Ten stall cycles
        for (int k = 0; k < 10; k++) step(0, 2'b11, 2'b01, 0, 0, 0, 0);
        step(0, 2'b11, 2'b00, 0, 0, 0, 0);
`ifdef LFA_RD_CTRL_STATS_EN
        chk("stall_10", 70'(stall_cnt), 70'(10));
`else
        chk("stall_off", 70'(stall_cnt), 70'(0));
`endif
        fifo_waddr = 10'd1020;
        step(0, 2'b11, 2'b00, 0, 0, 0, 1);
        step(0, 2'b11, 2'b00, 0, 0, 0, 0);
        chk("stall_flush_clr", 70'(stall_cnt), 70'(0));

        // Wrap at 1023 and release across the wrap
        step(0, 2'b11, 2'b01, 1, 0, 0, 0);
        chk("wr_ack", 70'(fifo_rd_ack), 70'(1)); chk("wr_ack_addr", 70'(fifo_rd_ack_addr), 70'(1020));
        chk("wr_raddr0", 70'(fifo_raddr), 70'(1020));
        step(0, 2'b11, 2'b01, 1, 0, 0, 0);
        step(0, 2'b11, 2'b01, 1, 0, 0, 0);
        step(0, 2'b11, 2'b01, 1, 0, 0, 0);
        chk("wr_raddr3", 70'(fifo_raddr), 70'(1023)); chk("wr_gnt3", 70'(gnt), 70'(1));
        step(0, 2'b11, 2'b00, 0, 2'b01, 0, 0);
        chk("wr_rdata", rdata, word(1023));
        step(0, 2'b11, 2'b01, 1, 0, 0, 0);
        chk("wr_raddr_wrap", 70'(fifo_raddr), 70'(0)); chk("wr_gnt_wrap", 70'(gnt), 70'(1));
        step(0, 2'b11, 2'b00, 0, 0, 0, 0);
        chk("wr_noack_lag", 70'(fifo_rd_ack), 70'(0));
        for (int k = 0; k < 4; k++) begin
            step(0, 2'b11, 2'b10, 1, 0, 0, 0);
            chk("wr_r1_raddr", 70'(fifo_raddr), 70'(1020 + k));
        end
        step(0, 2'b11, 2'b00, 0, 2'b10, 0, 0);
        step(0, 2'b11, 2'b00, 0, 0, 0, 0);
        chk("wr_ack_early", 70'(fifo_rd_ack), 70'(0));
        step(0, 2'b11, 2'b00, 0, 0, 0, 0);
        chk("wr_ack_wrap", 70'(fifo_rd_ack), 70'(1)); chk("wr_ack_addr_wrap", 70'(fifo_rd_ack_addr), 70'(0));
        step(0, 2'b11, 2'b00, 0, 0, 0, 0);
        chk("wr_ack_once", 70'(fifo_rd_ack), 70'(0));

        // Disabled requester 1: no grant, and excluded from release
        step(0, 2'b01, 2'b10, 1, 2'b01, 0, 0);
        chk("dis_gnt", 70'(gnt), 70'(0)); chk("dis_rd", 70'(fifo_rd), 70'(0));
        step(0, 2'b01, 2'b00, 0, 0, 0, 0);
        step(0, 2'b01, 2'b00, 0, 0, 0, 0);
        chk("dis_ack", 70'(fifo_rd_ack), 70'(1)); chk("dis_ack_addr", 70'(fifo_rd_ack_addr), 70'(1));

        // Reset mid-operation drops the pending rvalid
        step(0, 2'b11, 2'b01, 1, 0, 0, 0);
        chk("mr_gnt", 70'(gnt), 70'(1)); chk("mr_raddr", 70'(fifo_raddr), 70'(1));
        step(1, 2'b11, 2'b01, 1, 0, 0, 0);
        chk("mr_rvalid", 70'(rvalid), 70'(0)); chk("mr_gnt_rst", 70'(gnt), 70'(0));
        step(0, 2'b11, 2'b00, 0, 0, 0, 0);
        chk("mr_rvalid_after", 70'(rvalid), 70'(0)); chk("mr_rdata", rdata, 70'(0));
        chk("mr_ack_addr", 70'(fifo_rd_ack_addr), 70'(0));
        step(0, 2'b11, 2'b01, 1, 0, 0, 0);
        chk("mr_raddr_after", 70'(fifo_raddr), 70'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
